famiclone_detect: RTL

Power-on famiclone detector for the cartridge glue. It holds CIRAM /CE and PPU /A13 low for a programmable number of M2 cycles after reset, then probes PPU reads to decide whether the console is a "new Dendy" clone that does not honour CIRAM /CE. It also exposes a force override and a re-probe request. It sits beside the mapper logic in the top level, and its outputs gate `ppu_ciram_ce` / `ppu_not_a13_out` tri-stating.

---
 rtl/famiclone_pkg.sv | 26 ++
 rtl/famiclone_detect_if.sv | 27 ++
 rtl/ppu_rd_sampler.sv | 41 ++++
 rtl/famiclone_detect.sv | 118 +++++++++++
 4 files changed

// File: rtl/famiclone_pkg.sv
// famiclone_pkg: shared types and encodings for the famiclone detector.
//   state_e          : detector FSM states
//   FORCE_*          : force_mode encodings (2'b11 behaves as auto)
//   cnt_width()      : counter width wide enough for every parameter
package famiclone_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] FORCE_AUTO    = 2'b00;
  localparam logic [1:0] FORCE_CLASSIC = 2'b01;
  localparam logic [1:0] FORCE_NEW     = 2'b10;

  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/famiclone_detect_if.sv
// famiclone_detect_if: PPU probe inputs, control inputs and detector status.
//   master : console/glue side, drives PPU lines, force_mode and restart
//   slave  : detector side, returns grounding/detection status
interface famiclone_detect_if #(
  parameter int CNT_W = 5
);
  logic             ppu_rd_in;
  logic             ppu_a13;
  logic             ppu_not_a13;
  logic [1:0]       force_mode;
  logic             restart;
  logic             ground_en;
  logic             init_done;
  logic             detect_done;
  logic             new_dendy;
  logic [CNT_W-1:0] mismatch_cnt;

  modport master (
    output ppu_rd_in, ppu_a13, ppu_not_a13, force_mode, restart,
    input  ground_en, init_done, detect_done, new_dendy, mismatch_cnt
  );

  modport slave (
    input  ppu_rd_in, ppu_a13, ppu_not_a13, force_mode, restart,
    output ground_en, init_done, detect_done, new_dendy, mismatch_cnt
  );
endinterface

// File: rtl/ppu_rd_sampler.sv
// ppu_rd_sampler: registers the PPU /RD, A13 and /A13 lines on every m2
// rising edge and flags a falling edge of the registered /RD.
//   m2, reset           : clock, async active-high reset
//   ppu_rd_i            : PPU /RD (active low)
//   ppu_a13_i           : PPU A13
//   ppu_not_a13_i       : console /A13
//   a13_s_o, not_a13_s_o: A13 / not-A13 captured with the current rd sample
//   rd_fall_o           : one-cycle strobe, registered rd went 1 -> 0
module ppu_rd_sampler (
  input  logic m2,
  input  logic reset,
  input  logic ppu_rd_i,
  input  logic ppu_a13_i,
  input  logic ppu_not_a13_i,
  output logic a13_s_o,
  output logic not_a13_s_o,
  output logic rd_fall_o
);

  logic rd_q, rd_prev_q, a13_q, not_a13_q;

  // /RD idles high, so reset both rd stages high to avoid a spurious event.
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      rd_q      <= 1'b1;
      rd_prev_q <= 1'b1;
      a13_q     <= 1'b0;
      not_a13_q <= 1'b0;
    end else begin
      rd_q      <= ppu_rd_i;
      rd_prev_q <= rd_q;
      a13_q     <= ppu_a13_i;
      not_a13_q <= ppu_not_a13_i;
    end
  end

  assign a13_s_o     = a13_q;
  assign not_a13_s_o = not_a13_q;
  assign rd_fall_o   = rd_prev_q & ~rd_q;

endmodule

// File: rtl/famiclone_detect.sv
// famiclone_detect: power-on grounding window followed by a PPU read probe
// that detects clones ignoring CIRAM /CE ("new Dendy").
//   m2, reset : sole clock (rising edge), async active-high reset
//   bus       : slave modport of famiclone_detect_if (PPU lines, force_mode,
//               restart in; ground_en, init_done, detect_done, new_dendy,
//               mismatch_cnt out)
//
// state | meaning
// INIT  | grounding window, counts INIT_CYCLES m2 edges
// PROBE | collecting low/high A13 reads, counting A13 / not-A13 agreement
// DONE  | result frozen until restart or reset
module famiclone_detect
  import famiclone_pkg::*;
#(
  parameter int INIT_CYCLES        = 15,
  parameter int LOW_SAMPLES        = 3,
  parameter int HIGH_SAMPLES       = 3,
  parameter int MISMATCH_THRESHOLD = 1,
  parameter int CNT_W = cnt_width(INIT_CYCLES, LOW_SAMPLES, HIGH_SAMPLES, MISMATCH_THRESHOLD)
) (
  input logic               m2,
  input logic               reset,
  famiclone_detect_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_CYCLES);
  localparam logic [CNT_W-1:0] LOW_LOAD   = CNT_W'(LOW_SAMPLES);
  localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(HIGH_SAMPLES);
  localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(MISMATCH_THRESHOLD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             detected_q, detected_d;

  logic a13_s, not_a13_s, rd_fall;

  ppu_rd_sampler u_sampler (
    .m2            (m2),
    .reset         (reset),
    .ppu_rd_i      (bus.ppu_rd_in),
    .ppu_a13_i     (bus.ppu_a13),
    .ppu_not_a13_i (bus.ppu_not_a13),
    .a13_s_o       (a13_s),
    .not_a13_s_o   (not_a13_s),
    .rd_fall_o     (rd_fall)
  );

  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      state_q        <= INIT;
      init_cnt_q     <= INIT_LOAD;
      low_cnt_q      <= LOW_LOAD;
      high_cnt_q     <= HIGH_LOAD;
      mismatch_cnt_q <= '0;
      detected_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      low_cnt_q      <= low_cnt_d;
      high_cnt_q     <= high_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      detected_q     <= detected_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    low_cnt_d      = low_cnt_q;
    high_cnt_d     = high_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    detected_d     = detected_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q - ONE;
        if (init_cnt_q == ONE) state_d = PROBE;
      end
      PROBE, DONE: begin
        // restart takes priority over a read event on the same edge
        if (bus.restart) begin
          state_d        = PROBE;
          low_cnt_d      = LOW_LOAD;
          high_cnt_d     = HIGH_LOAD;
          mismatch_cnt_d = '0;
          detected_d     = 1'b0;
        end else if (state_q == PROBE && rd_fall) begin
          // Agreement only counts while both halves are still open; once one
          // side is exhausted the remaining reads just close the other side.
          if (low_cnt_q != '0 && high_cnt_q != '0 && a13_s == not_a13_s &&
              mismatch_cnt_q != '1)
            mismatch_cnt_d = mismatch_cnt_q + ONE;
          if (!a13_s && low_cnt_q != '0)  low_cnt_d  = low_cnt_q - ONE;
          if (a13_s && high_cnt_q != '0)  high_cnt_d = high_cnt_q - ONE;
          if (mismatch_cnt_d >= THRESH_CNT) detected_d = 1'b1;
          if (low_cnt_d == '0 && high_cnt_d == '0) state_d = DONE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    bus.ground_en    = (state_q == INIT);
    bus.init_done    = (state_q != INIT);
    bus.detect_done  = (state_q == DONE);
    bus.mismatch_cnt = mismatch_cnt_q;
    unique case (bus.force_mode)
      FORCE_CLASSIC: bus.new_dendy = 1'b0;
      FORCE_NEW:     bus.new_dendy = 1'b1;
      default:       bus.new_dendy = detected_q && (state_q != INIT);
    endcase
  end

endmodule
